frame_display_reader: RTL
=========================

FRAME_DISPLAY_READER -- requirements
Module: frame_display_reader

Interface
REQ-001 Parameter LIVE_COLOR, default 12'hFFF: rgb value driven for a live cell (data_in=1) in the visible area.
REQ-002 Parameter DEAD_COLOR, default 12'h000: rgb value driven for a dead cell (data_in=0) in the visible area.
REQ-003 Port clk  input  1  pixel clock (25 MHz nominal); all logic is on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port rd_addr_x  output  10  frame-buffer read column, 0..639.
REQ-006 Port rd_addr_y  output  9  frame-buffer read row, 0..479.
REQ-007 Port rd_en  output  1  high while the read address is in the visible area.
REQ-008 Port data_in  input  1  cell bit; memory returns it one cycle after the address.
REQ-009 Port hsync  output  1  horizontal sync, active-low.
REQ-010 Port vsync  output  1  vertical sync, active-low.
REQ-011 Port rgb  output  12  pixel colour, 4 bits each R,G,B.
REQ-012 Port frame_done  output  1  single-cycle pulse when the last visible pixel's read has been issued; drives the start input of the frame-buffer copy block.

Function
REQ-013 Horizontal counter h_cnt SHALL count 0..799, then wrap to 0; vertical counter v_cnt SHALL increment when h_cnt wraps and wrap from 524 to 0.
REQ-014 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-015 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-016 Stage 0 (counter cycle): active = (h_cnt<640)&(v_cnt<480); rd_addr_x/rd_addr_y SHALL equal h_cnt/v_cnt when active, 0 otherwise; rd_en = active. Address outputs are combinational from registered counters.
REQ-017 Stage 1: active, raw hsync, raw vsync SHALL be registered one cycle to align with data_in.
REQ-018 Stage 2: rgb SHALL be registered as LIVE_COLOR/DEAD_COLOR per data_in when stage-1 active, 12'h000 otherwise; hsync/vsync registered in the same cycle.
REQ-019 Total latency from counter value to hsync/vsync/rgb: exactly 2 cycles; all three outputs SHALL stay mutually aligned.
REQ-020 hsync SHALL be low for exactly 96 cycles per line; vsync low for exactly 2 lines (1600 cycles) per frame.
REQ-021 frame_done SHALL pulse high for one cycle, registered, in the cycle after stage 0 holds h_cnt=639, v_cnt=479; exactly one pulse per 420000-cycle frame.
REQ-022 data_in SHALL be ignored when stage-1 active is low (no X propagation to rgb in blanking).
REQ-023 Simultaneous wrap (h_cnt=799, v_cnt=524) SHALL take both counters to 0 in the same edge.

Reset
REQ-024 On rst_n low, asynchronously: h_cnt=0, v_cnt=0, pipeline active=0, hsync=1, vsync=1, rgb=12'h000, frame_done=0.
REQ-025 Reset mid-frame SHALL abort the frame with no frame_done pulse; after release, frame restarts at (0,0) and first visible rgb appears on the 3rd rising edge.

Structure
REQ-026 Package conway_pkg SHALL hold H_VISIBLE/H_FP/H_SYNC/H_BP/H_TOTAL, V_* equivalents, X_MAX=639, Y_MAX=479 and default colours; the copy block shares X_MAX/Y_MAX.
REQ-027 One sub-module vga_sync_counter SHALL own h_cnt/v_cnt and emit active, raw hsync, raw vsync, last_pixel; frame_display_reader owns the pipeline and colour mapping.

Verification
REQ-028 Reset release, data_in=1 always -> rd_addr=(0,0) on cycle 0; rgb=12'hFFF from cycle 2 for 640 cycles, then 12'h000 for 160.
REQ-029 Line timing -> hsync falls 2 cycles after h_cnt=656, low 96 cycles; period 800 cycles; vsync low cycles 490*800+2 .. 492*800+1.
REQ-030 Memory model returning checkerboard (x^y)&1 -> rgb alternates DEAD/LIVE per pixel starting DEAD at (0,0), LIVE at (0,1).
REQ-031 Run 3 frames -> frame_done pulses exactly 3 times, 420000 cycles apart, first at cycle 479*800+640.
REQ-032 Assert rst_n low at (h=300,v=200) for 5 cycles -> outputs at reset values immediately, no frame_done, rd_addr=(0,0) after release.
REQ-033 data_in=X during blanking -> rgb remains 12'h000, rd_en=0, rd_addr=(0,0).

Source files
------------

// File: rtl/conway_pkg.sv
`timescale 1ns/1ps
// Shared VGA 640x480@60 timing constants, frame extents and colour defaults.
// Latency: n/a (constants and types only).
// Backpressure: n/a; the display path is free running and never stalls.
package conway_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Last visible cell coordinates, shared with the frame-buffer copy block
    localparam int X_MAX = H_VISIBLE - 1;
    localparam int Y_MAX = V_VISIBLE - 1;

    localparam logic [11:0] LIVE_COLOR_DEFAULT = 12'hFFF;
    localparam logic [11:0] DEAD_COLOR_DEFAULT = 12'h000;
    localparam logic [11:0] BLANK_COLOR        = 12'h000;

    // Timing qualifiers carried down the pipeline alongside the pixel data
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_t;

    // Blanked, sync lines de-asserted (high)
    localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_sync_counter.sv
`timescale 1ns/1ps
// Free-running raster position counters with raw (unpipelined) timing decode.
// Latency: outputs are combinational from the registered counters (stage 0).
// Backpressure: none; counters advance every clock.
module vga_sync_counter
    import conway_pkg::*;
#(
    parameter int H_VIS    = H_VISIBLE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_VIS    = V_VISIBLE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       last_pixel
);

    localparam logic [9:0] H_VIS_END = 10'(H_VIS);
    localparam logic [9:0] HS_START  = 10'(H_VIS + H_FRONT);
    localparam logic [9:0] HS_END    = 10'(H_VIS + H_FRONT + H_SYNC_W);
    localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FRONT + H_SYNC_W + H_BACK - 1);
    localparam logic [9:0] X_LAST    = 10'(H_VIS - 1);

    localparam logic [9:0] V_VIS_END = 10'(V_VIS);
    localparam logic [9:0] VS_START  = 10'(V_VIS + V_FRONT);
    localparam logic [9:0] VS_END    = 10'(V_VIS + V_FRONT + V_SYNC_W);
    localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FRONT + V_SYNC_W + V_BACK - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_VIS - 1);

    logic [9:0] h_cnt_d, h_cnt_q;
    logic [9:0] v_cnt_d, v_cnt_q;

    // Next raster position: line wrap bumps the row, and the frame wrap clears both together
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Raster position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign active     = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    assign hsync_raw  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vsync_raw  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign last_pixel = (h_cnt_q == X_LAST) && (v_cnt_q == Y_LAST);

endmodule

// File: rtl/frame_display_reader.sv
`timescale 1ns/1ps
// Scans the cell frame buffer in raster order and maps cell bits to VGA colour.
// Latency: 2 cycles from raster position to hsync/vsync/rgb; frame_done 1 cycle.
// Backpressure: none; the memory must return data_in exactly one cycle after rd_addr.
module frame_display_reader
    import conway_pkg::*;
#(
    parameter logic [11:0] LIVE_COLOR = LIVE_COLOR_DEFAULT,
    parameter logic [11:0] DEAD_COLOR = DEAD_COLOR_DEFAULT,
    parameter int          H_VIS      = H_VISIBLE,
    parameter int          H_FRONT    = H_FP,
    parameter int          H_SYNC_W   = H_SYNC,
    parameter int          H_BACK     = H_BP,
    parameter int          V_VIS      = V_VISIBLE,
    parameter int          V_FRONT    = V_FP,
    parameter int          V_SYNC_W   = V_SYNC,
    parameter int          V_BACK     = V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  rd_addr_x,
    output logic [8:0]  rd_addr_y,
    output logic        rd_en,
    input  logic        data_in,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_done
);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       last_pixel;

    vga_sync_counter #(
        .H_VIS    (H_VIS),
        .H_FRONT  (H_FRONT),
        .H_SYNC_W (H_SYNC_W),
        .H_BACK   (H_BACK),
        .V_VIS    (V_VIS),
        .V_FRONT  (V_FRONT),
        .V_SYNC_W (V_SYNC_W),
        .V_BACK   (V_BACK)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .last_pixel (last_pixel)
    );

    sync_t       s1_d, s1_q;
    logic [11:0] rgb_d, rgb_q;
    logic        hsync_d, hsync_q;
    logic        vsync_d, vsync_q;
    logic        frame_done_d, frame_done_q;

    // Stage 0 read address: parked at (0,0) outside the visible area.
    // Row bit 9 is always clear while active; it is folded in so every counter bit is used.
    always_comb begin
        rd_addr_x = '0;
        rd_addr_y = '0;
        if (active && !v_cnt[9]) begin
            rd_addr_x = h_cnt;
            rd_addr_y = v_cnt[8:0];
        end
    end

    assign rd_en = active;

    // Stage 1 delays the timing qualifiers to line up with data_in; stage 2 maps colour.
    // data_in is only looked at when the delayed active is set, so blanking never sees it.
    always_comb begin
        s1_d         = '{active: active, hsync: hsync_raw, vsync: vsync_raw};
        rgb_d        = BLANK_COLOR;
        if (s1_q.active) begin
            rgb_d = data_in ? LIVE_COLOR : DEAD_COLOR;
        end
        hsync_d      = s1_q.hsync;
        vsync_d      = s1_q.vsync;
        frame_done_d = last_pixel;
    end

    // Pipeline registers; reset blanks the screen and de-asserts both syncs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= SYNC_IDLE;
            rgb_q        <= BLANK_COLOR;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_done = frame_done_q;

endmodule
